// File: rtl/fifo_pop_pkg.sv
// Shared types and defaults for the FIFO read-side pop controller.
package fifo_pop_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pop_state_t;

   localparam int DATA_W_DEF = 8;

endpackage : fifo_pop_pkg

// File: rtl/fifo_pop_ctrl_sva.sv
// Protocol checker bound onto fifo_pop_ctrl: no FIFO underflow, bounded occupancy, stable held data.
module fifo_pop_ctrl_sva #(
   parameter int DATA_W    = 8,
   parameter int BUF_DEPTH = 2,
   parameter int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
   input logic              clk,
   input logic              rst,
   input logic              fifo_rd,
   input logic              fifo_empty,
   input logic [OCC_W-1:0]  occ,
   input logic              m_valid,
   input logic              m_ready,
   input logic [DATA_W-1:0] m_data
);

   a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
      fifo_rd |-> !fifo_empty);

   a_occ_bound : assert property (@(posedge clk) disable iff (!rst)
      occ <= OCC_W'(BUF_DEPTH));

   a_data_hold : assert property (@(posedge clk) disable iff (!rst)
      (m_valid && !m_ready) |=> $stable(m_data));

endmodule : fifo_pop_ctrl_sva

// File: rtl/fifo_pop_skid.sv
// Circular skid buffer that absorbs the FIFO read latency; head entry drives the output.
module fifo_pop_skid
   import fifo_pop_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BUF_DEPTH = 2,
   parameter int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [OCC_W-1:0]  occ_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;

   // Pointers wrap at BUF_DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (push_i) wptr_d = next_ptr(wptr_q);
      if (pop_i)  rptr_d = next_ptr(rptr_q);
      if (push_i && !pop_i)      occ_d = occ_q + 1'b1;
      else if (!push_i && pop_i) occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
         if (push_i) mem_q[wptr_q] <= push_data_i;
      end
   end

   assign occ_o   = occ_q;
   assign valid_o = (occ_q != '0);
   assign data_o  = mem_q[rptr_q];

endmodule : fifo_pop_skid

// File: rtl/fifo_pop_ctrl.sv
// Read-side FIFO controller: issues rd only when space is guaranteed, streams words out in order.
module fifo_pop_ctrl
   import fifo_pop_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BUF_DEPTH = 2,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_d_out,
   output logic              fifo_rd,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              idle,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   pop_state_t       state_q, state_d;
   logic             inflight_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   need;
   logic             pop;
   logic             space_ok;

   assign pop = m_valid && m_ready;

   // Space check counts the word still in flight and credits a same-cycle pop,
   // so m_ready reaches fifo_rd combinationally.
   assign need     = {1'b0, occ} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
   assign space_ok = need < (OCC_W + 1)'(BUF_DEPTH);
   assign fifo_rd  = (state_q == RUN) && !fifo_empty && space_ok;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)                                state_d = RUN;
            else if (!inflight_q && occ == '0)     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= fifo_rd;
         if (pop) word_cnt_q <= word_cnt_q + 1'b1;
      end
   end

   fifo_pop_skid #(
      .DATA_W    (DATA_W),
      .BUF_DEPTH (BUF_DEPTH),
      .OCC_W     (OCC_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (fifo_d_out),
      .pop_i       (pop),
      .occ_o       (occ),
      .valid_o     (m_valid),
      .data_o      (m_data)
   );

   assign idle     = (state_q == IDLE);
   assign word_cnt = word_cnt_q;

endmodule : fifo_pop_ctrl

// File: doc/fifo_pop_ctrl.md
# fifo_pop_ctrl

Read-side controller sitting directly downstream of the synchronous FIFO. It issues `rd` pulses only when the FIFO is non-empty and local space is guaranteed, and absorbs the FIFO's one-cycle read latency in a small skid buffer. It presents the words in order on a valid/ready stream to the next consumer. It also provides enable/drain control and a delivered-word counter.

## Interface

Parameters:
- `DATA_W`, 8: width of FIFO `d_out` and of `m_data`.
- `BUF_DEPTH`, 2: skid buffer entries; legal values are 2..8.
- `CNT_W`, 16: width of `word_cnt`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 = fetch from FIFO; 0 = stop fetching and drain.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_d_out`  in  DATA_W  FIFO `d_out`.
- `fifo_rd`  out  1  FIFO `rd` strobe.
- `m_valid`  out  1  output word available.
- `m_data`  out  DATA_W  output word; head of the skid buffer.
- `m_ready`  in  1  consumer accepts when high with `m_valid`.
- `idle`  out  1  high in IDLE state.
- `word_cnt`  out  CNT_W  words accepted downstream since reset; wraps modulo 2^CNT_W.

## Operation

- FIFO read contract:
  - `rd` sampled high at edge N with `empty`=0 gives valid `d_out` during the cycle after edge N.
  - The controller captures that word at edge N+1.
- Counters:
  - `occ` is the number of buffer entries, 0..BUF_DEPTH.
  - `inflight` is 0 or 1: a read issued on the previous edge.
  - `pop` = `m_valid && m_ready`.
- `fifo_rd` is combinational and equals `state==RUN && !fifo_empty && (occ + inflight - pop) < BUF_DEPTH`.
  - This gives a combinational path from `m_ready` to `fifo_rd`; it is intentional.
  - `fifo_rd` is never high while `fifo_empty`=1, so the FIFO cannot underflow.
- Skid buffer:
  - A circular buffer with write pointer, read pointer, and `occ`.
  - Push happens when `inflight`=1; it captures `fifo_d_out`.
  - Push and pop in the same cycle are both performed, and `occ` is unchanged.
  - Pointers wrap at BUF_DEPTH.
- `m_valid` = (`occ`!=0). `m_data` = entry at the read pointer, held stable while `m_valid && !m_ready`.
- `word_cnt` increments on every `pop`.
- States:
  - IDLE:
    - `idle`=1 and no reads are issued.
    - Goes to RUN when `en`=1.
  - RUN:
    - Reads are issued per the rule above.
    - Goes to DRAIN when `en`=0.
  - DRAIN:
    - No new reads; the in-flight word is still captured.
    - Goes to RUN if `en`=1.
    - Goes to IDLE when `inflight`=0, `occ`=0 and `en`=0.
- Reset values:
  - `fifo_rd`=0, `m_valid`=0, `m_data`=0 (all entries cleared), `idle`=1, `word_cnt`=0.
  - State=IDLE, `occ`=0, `inflight`=0, both pointers 0.

## Timing

- Latency: first `rd` edge to `m_valid` high is 1 cycle. FIFO `empty` falling to `m_valid` is 2 edges when `en`=1.
- Throughput with BUF_DEPTH≥2 and `m_ready` held at 1 is one word per cycle, sustained.
- Backpressure: with `m_ready`=0, at most BUF_DEPTH words are buffered plus none in flight; reads stop and no word is lost.
- `en` falling while a read is in flight: that word is captured and delivered before IDLE.
- Asynchronous reset mid-operation:
  - All state clears immediately.
  - An in-flight FIFO word is discarded; the FIFO has already consumed it.
- `fifo_empty` rising on the same edge as a read: the read was legal because `empty` was 0 when sampled, and the word is captured normally.

## Structure

- Package `fifo_pop_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN} pop_state_t`.
  - Default `DATA_W`.
- Sub-module `fifo_pop_skid`: the circular buffer with `occ`, pointers and push/pop. The top level holds the FSM, the read issue logic, `inflight` and `word_cnt`.
- Assertions, bound to the instance in a separate checker module:
  - `fifo_rd` implies `!fifo_empty`.
  - `occ` ≤ BUF_DEPTH.
  - `m_data` is stable while `m_valid && !m_ready`.

## Test plan

- Reset then `en`=1 with the FIFO preloaded with 0x11, 0x22, 0x33 and `m_ready`=1 → `m_data` shows 0x11, 0x22, 0x33 on consecutive cycles; `word_cnt`=3; no `fifo_rd` once `empty`=1.
- FIFO holds 6 words and `m_ready`=0 → exactly 2 `rd` pulses, `m_valid`=1 with `m_data`=word0 held; after `m_ready`=1 all 6 words arrive in order, one per cycle.
- `m_ready` toggling 1,0,1,0 on a 10-word stream → no drop or duplicate; `word_cnt`=10; `fifo_rd` never high while `fifo_empty`=1.
- `en` dropped in the same cycle as a `rd` → state DRAIN, in-flight word delivered, then `idle`=1 and no further `rd`.
- Assert `rst`=0 with 2 words buffered and 1 in flight → `m_valid`=0, `word_cnt`=0, `idle`=1 immediately; after release, the next word from the FIFO is delivered first.
- Drive `word_cnt` to 0xFFFF and accept one more word → `word_cnt`=0x0000.
